seq_alu: RTL
============

Name: seq_alu

Overview:
- Parametrised, clocked successor to the team's combinational 4-op ALU (add, sub, mul, div).
- Operand width is a parameter.
- Multiply and divide run as multi-cycle iterative units (shift-add, restoring division).
- A start/busy/done handshake lets a controller or testbench launch one operation at a time and collect a registered result and error flag.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32); result width is 2*WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  launch request; sampled only when busy=0
- a  input  WIDTH  operand A, unsigned; captured on accepted start
- b  input  WIDTH  operand B, unsigned; captured on accepted start
- op  input  2  operation: 00 add, 01 sub, 10 mul, 11 div
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when result/error become valid
- result  output  2*WIDTH  registered result; held until the next accepted start
- error  output  1  divide-by-zero flag; valid with done, held with result

Behaviour:
- Reset (async assert, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, result=0, error=0.
  - Internal operand, accumulator and count registers cleared.
  - An in-flight operation is discarded; no done pulse follows.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start=1 at edge T: capture a, b, op.
  - add/sub, or div with b=0: go to FINISH.
  - mul, or div with b!=0: go to RUN with count=0, and busy=1 after edge T.
- RUN:
  - One iteration per clock; count increments.
  - After WIDTH iterations (count==WIDTH-1 at the edge), go to FINISH.
- FINISH:
  - For one cycle: done=1, busy=0, result/error updated.
  - Return to IDLE on the next edge.
  - start is ignored while in FINISH.
- Latency, measured from the accepting edge T to the cycle done is high:
  - add, sub, div-by-zero: done high during cycle T+1.
  - mul, div with b!=0: done high during cycle T+WIDTH+1.
- start while busy=1 or in FINISH: ignored. Operands and op are not re-sampled; the in-progress operation is unaffected.
- Back-to-back: start may be asserted in the cycle after done (state IDLE). Minimum issue interval is 2 cycles for add/sub.
- Arithmetic, all unsigned:
  - add: result = zero-extended WIDTH+1-bit sum; carry appears in bit WIDTH.
  - sub: result = (a - b) modulo 2^(2*WIDTH), i.e. sign-extended two's-complement difference.
  - mul: shift-add; result = a*b, full 2*WIDTH bits, no overflow possible.
  - div (restoring):
    - result[WIDTH-1:0] = quotient; result[2*WIDTH-1:WIDTH] = remainder.
    - Quotient bits are produced MSB first, one per RUN cycle.
  - div with b=0: error=1, result=0.
- error is cleared to 0 on every accepted start. It is set only for div by zero.
- result is updated only at the edge entering FINISH. Its previous value holds through RUN (no partial values visible).
- Input changes on a, b, op after acceptance have no effect.

Optional Feature:
- Macro: SEQ_ALU_FLAGS_EN.
- Defined: adds two output ports, each registered and updated with result in FINISH, and reset to 0.
  - zero  output  1: set when result==0.
  - ovf  output  1:
    - add: set on carry-out of WIDTH bits (result[WIDTH]).
    - sub: set on borrow (a<b).
    - mul: set when result[2*WIDTH-1:WIDTH]!=0.
    - div: 0.
- Not defined: ports are absent and no flag logic is synthesised; all other behaviour is identical.

Test Plan (WIDTH=8):
- Reset and add:
  - Stimulus: rst pulse, then start with a=10, b=20, op=00.
  - Response: done in cycle T+1, result=16'd30, error=0, busy never asserted.
- Subtraction with borrow:
  - Stimulus: a=15, b=30, op=01.
  - Response: result=16'hFFF1.
  - Stimulus: a=30, b=15.
  - Response: result=16'd15.
  - With SEQ_ALU_FLAGS_EN: ovf=1 then 0.
- Multiply:
  - Stimulus: a=5, b=3, op=10.
  - Response: busy high for cycles T+1..T+8, done at T+9, result=16'd15.
  - Stimulus: a=255, b=255.
  - Response: result=16'hFE01.
- Divide:
  - Stimulus: a=43, b=8, op=11.
  - Response: done at T+9, result=16'h0305 (rem 3, quot 5).
  - Stimulus: a=40, b=8.
  - Response: result=16'h0005.
- Divide by zero:
  - Stimulus: a=40, b=0, op=11.
  - Response: done at T+1, error=1, result=0.
  - Stimulus: next start with add.
  - Response: error clears to 0.
- Protocol/reset:
  - Stimulus: during a mul, pulse start with a different op.
  - Response: ignored, original result delivered.
  - Stimulus: assert rst mid-div.
  - Response: outputs 0 immediately, no done pulse; a fresh start afterwards completes correctly.

Source files
------------

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential add/sub/mul/div ALU with start/busy/done handshake
// Optional zero/ovf flag outputs are enabled by defining SEQ_ALU_FLAGS_EN.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         op,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
`ifdef SEQ_ALU_FLAGS_EN
    output logic               zero,
    output logic               ovf,
`endif
    output logic               error
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t             state, state_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [1:0]         op_q;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc, acc_step, quick_result;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge, accept, last_iter;

    assign accept    = (state == IDLE) && start;
    assign last_iter = (state == RUN) && (count == CW'(WIDTH - 1));

    // acc holds {hi, lo}: mul shifts the product right through it with b in lo,
    // div shifts the dividend left out of lo while quotient bits enter at bit 0.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = (div_shift >= {1'b0, b_q});
        if (op_q == OP_MUL)
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        else
            acc_step = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc[WIDTH-2:0], div_ge};
    end

    always_comb begin
        quick_result = '0;
        case (op)
            OP_ADD:  quick_result = {{(WIDTH-1){1'b0}}, ({1'b0, a} + {1'b0, b})};
            OP_SUB:  quick_result = {{WIDTH{1'b0}}, a} - {{WIDTH{1'b0}}, b};
            default: quick_result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_d = (op == OP_MUL || (op == OP_DIV && b != '0)) ? RUN : FINISH;
            end
            RUN: begin
                busy = 1'b1;
                if (count == CW'(WIDTH - 1)) state_d = FINISH;
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            count  <= '0;
            acc    <= '0;
            result <= '0;
            error  <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            count <= '0;
            acc   <= (op == OP_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
            error <= 1'b0;
            if (state_d == FINISH) begin
                // single-cycle ops and divide-by-zero resolve at the accepting edge
                result <= quick_result;
                error  <= (op == OP_DIV);
            end
        end else if (state == RUN) begin
            acc   <= acc_step;
            count <= count + CW'(1);
            if (last_iter) result <= acc_step;
        end
    end

`ifdef SEQ_ALU_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else if (accept && state_d == FINISH) begin
            zero <= (quick_result == '0);
            ovf  <= (op == OP_ADD) ? quick_result[WIDTH] : ((op == OP_SUB) && (a < b));
        end else if (last_iter) begin
            zero <= (acc_step == '0);
            ovf  <= (op_q == OP_MUL) && (acc_step[2*WIDTH-1:WIDTH] != '0);
        end
    end
`endif

endmodule
